id_ex_stage: RTL and testbench

- ID/EX pipeline register that sits directly upstream of the execute-stage ALU.
- Captures decoded instruction fields and register-file operands each cycle and presents them to the ALU.
- Applies MEM/WB operand forwarding, detects load-use hazards and inserts a bubble.
- Honours downstream stall and branch/jump flush.

---
 rtl/id_ex_stage.sv | 172 +++++++++++++++++
 tb/tb_id_ex_stage.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_stage.sv
// -----------------------------------------------------------------------------
// id_ex_stage
//   ID/EX pipeline register in front of the execute-stage ALU. Captures the
//   decoded instruction and its register-file operands, resolves MEM/WB
//   forwarding on the registered operands, detects load-use hazards (inserting
//   one bubble) and honours downstream stall and branch/jump flush.
//
// Ports
//   clk, rst_n          : clock (rising edge), asynchronous active-low reset
//   id_*                : decoded instruction and register-file reads from ID
//   ex_stall            : EX/MEM cannot advance; everything here holds
//   flush               : taken branch/jump in EX; kills the instruction in ID
//   mem_fwd_*/wb_fwd_*  : forwarding sources from MEM and WB
//   id_stall            : decode/fetch must hold (combinational)
//   ex_valid, ex_*      : registered instruction presented to EX
//   ex_aluIn1/2         : forwarded ALU operands (combinational from state)
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
`ifndef WORD_SIZE
`define WORD_SIZE 32
`endif

module id_ex_stage #(
   parameter int WORD_SIZE  = `WORD_SIZE,
   parameter int REG_ADDR_W = 5
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  id_valid,
   input  logic [WORD_SIZE-1:0]  id_pc,
   input  logic [6:0]            id_opcode,
   input  logic [6:0]            id_funct7,
   input  logic [2:0]            id_funct3,
   input  logic [REG_ADDR_W-1:0] id_rs1,
   input  logic [REG_ADDR_W-1:0] id_rs2,
   input  logic [REG_ADDR_W-1:0] id_rd,
   input  logic [WORD_SIZE-1:0]  id_rs1_data,
   input  logic [WORD_SIZE-1:0]  id_rs2_data,
   input  logic [WORD_SIZE-1:0]  id_imm,
   input  logic                  ex_stall,
   input  logic                  flush,
   input  logic                  mem_fwd_valid,
   input  logic [REG_ADDR_W-1:0] mem_fwd_rd,
   input  logic [WORD_SIZE-1:0]  mem_fwd_data,
   input  logic                  wb_fwd_valid,
   input  logic [REG_ADDR_W-1:0] wb_fwd_rd,
   input  logic [WORD_SIZE-1:0]  wb_fwd_data,
   output logic                  id_stall,
   output logic                  ex_valid,
   output logic [WORD_SIZE-1:0]  ex_pc,
   output logic [WORD_SIZE-1:0]  ex_imm,
   output logic [6:0]            ex_opcode,
   output logic [6:0]            ex_funct7,
   output logic [2:0]            ex_funct3,
   output logic [REG_ADDR_W-1:0] ex_rd,
   output logic [WORD_SIZE-1:0]  ex_aluIn1,
   output logic [WORD_SIZE-1:0]  ex_aluIn2
);

   localparam logic [6:0] OPCODE_LOAD   = 7'b0000011;
   localparam logic [6:0] OPCODE_STORE  = 7'b0100011;
   localparam logic [6:0] OPCODE_BRANCH = 7'b1100011;
   localparam logic [6:0] OPCODE_JUMP   = 7'b1101111;
   localparam logic [6:0] OPCODE_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPCODE_ALU    = 7'b0110011;

   logic                  r_valid;
   logic [WORD_SIZE-1:0]  r_pc;
   logic [WORD_SIZE-1:0]  r_imm;
   logic [6:0]            r_opcode;
   logic [6:0]            r_funct7;
   logic [2:0]            r_funct3;
   logic [REG_ADDR_W-1:0] r_rd;
   logic [REG_ADDR_W-1:0] r_rs1;
   logic [REG_ADDR_W-1:0] r_rs2;
   logic [WORD_SIZE-1:0]  r_rs1_data;
   logic [WORD_SIZE-1:0]  r_rs2_data;

   logic [WORD_SIZE-1:0]  w_alu_in1;
   logic [WORD_SIZE-1:0]  w_alu_in2;
   logic                  w_use_rs1;
   logic                  w_use_rs2;
   logic                  w_loaduse;

   function automatic logic uses_rs1(input logic [6:0] op);
      return (op != OPCODE_AUIPC) && (op != OPCODE_JUMP);
   endfunction

   function automatic logic uses_rs2(input logic [6:0] op);
      return (op == OPCODE_ALU) || (op == OPCODE_BRANCH) || (op == OPCODE_STORE);
   endfunction

   // MEM is younger than WB, so it wins; x0 is hard-wired and never forwarded.
   function automatic logic [WORD_SIZE-1:0] fwd_sel(
      input logic [REG_ADDR_W-1:0] rs,
      input logic [WORD_SIZE-1:0]  reg_data,
      input logic                  mem_v,
      input logic [REG_ADDR_W-1:0] mem_rd,
      input logic [WORD_SIZE-1:0]  mem_data,
      input logic                  wb_v,
      input logic [REG_ADDR_W-1:0] wb_rd,
      input logic [WORD_SIZE-1:0]  wb_data
   );
      if ((rs != '0) && mem_v && (mem_rd == rs)) return mem_data;
      if ((rs != '0) && wb_v && (wb_rd == rs))   return wb_data;
      return reg_data;
   endfunction

   always_comb begin
      w_alu_in1 = fwd_sel(r_rs1, r_rs1_data, mem_fwd_valid, mem_fwd_rd, mem_fwd_data,
                          wb_fwd_valid, wb_fwd_rd, wb_fwd_data);
      w_alu_in2 = fwd_sel(r_rs2, r_rs2_data, mem_fwd_valid, mem_fwd_rd, mem_fwd_data,
                          wb_fwd_valid, wb_fwd_rd, wb_fwd_data);
   end

   // Only source fields the ID opcode really reads may create a hazard, so an
   // AUIPC/JAL whose rs1 bit-field happens to alias the load's rd does not stall.
   assign w_use_rs1 = uses_rs1(id_opcode);
   assign w_use_rs2 = uses_rs2(id_opcode);
   assign w_loaduse = r_valid && (r_opcode == OPCODE_LOAD) && (r_rd != '0) && id_valid &&
                      ((w_use_rs1 && (id_rs1 == r_rd)) || (w_use_rs2 && (id_rs2 == r_rd)));

   // A flush kills the instruction in ID anyway, so a hazard against it is moot.
   assign id_stall = ex_stall | (w_loaduse & ~flush);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_valid    <= 1'b0;
         r_pc       <= '0;
         r_imm      <= '0;
         r_opcode   <= '0;
         r_funct7   <= '0;
         r_funct3   <= '0;
         r_rd       <= '0;
         r_rs1      <= '0;
         r_rs2      <= '0;
         r_rs1_data <= '0;
         r_rs2_data <= '0;
      end else if (ex_stall) begin
         // Fold forwarded values back into the operand registers: a WB write
         // that retires during the stall would otherwise be lost, since the
         // register-file read was taken before it happened.
         r_rs1_data <= w_alu_in1;
         r_rs2_data <= w_alu_in2;
      end else if (flush || w_loaduse) begin
         r_valid <= 1'b0;
      end else begin
         r_valid    <= id_valid;
         r_pc       <= id_pc;
         r_imm      <= id_imm;
         r_opcode   <= id_opcode;
         r_funct7   <= id_funct7;
         r_funct3   <= id_funct3;
         r_rd       <= id_rd;
         r_rs1      <= id_rs1;
         r_rs2      <= id_rs2;
         r_rs1_data <= id_rs1_data;
         r_rs2_data <= id_rs2_data;
      end
   end

   assign ex_valid  = r_valid;
   assign ex_pc     = r_pc;
   assign ex_imm    = r_imm;
   assign ex_opcode = r_opcode;
   assign ex_funct7 = r_funct7;
   assign ex_funct3 = r_funct3;
   assign ex_rd     = r_rd;
   assign ex_aluIn1 = w_alu_in1;
   assign ex_aluIn2 = w_alu_in2;

endmodule

// File: tb/tb_id_ex_stage.sv
`timescale 1ns/1ps
module tb_id_ex_stage;

   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_ALU    = 7'b0110011;
   localparam logic [6:0] OP_ALUI   = 7'b0010011;
   localparam logic [6:0] OPS [9] = '{OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL, OP_JALR,
                                      OP_AUIPC, OP_LUI, OP_ALU, OP_ALUI};

   logic        clk = 1'b0;
   logic        rst_n;
   logic        id_valid;
   logic [31:0] id_pc, id_imm, id_rs1_data, id_rs2_data;
   logic [6:0]  id_opcode, id_funct7;
   logic [2:0]  id_funct3;
   logic [4:0]  id_rs1, id_rs2, id_rd;
   logic        ex_stall, flush;
   logic        mem_fwd_valid, wb_fwd_valid;
   logic [4:0]  mem_fwd_rd, wb_fwd_rd;
   logic [31:0] mem_fwd_data, wb_fwd_data;
   logic        id_stall, ex_valid;
   logic [31:0] ex_pc, ex_imm, ex_aluIn1, ex_aluIn2;
   logic [6:0]  ex_opcode, ex_funct7;
   logic [2:0]  ex_funct3;
   logic [4:0]  ex_rd;

   always #5 clk = ~clk;

   id_ex_stage dut (
      .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_pc(id_pc),
      .id_opcode(id_opcode), .id_funct7(id_funct7), .id_funct3(id_funct3),
      .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
      .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
      .ex_stall(ex_stall), .flush(flush),
      .mem_fwd_valid(mem_fwd_valid), .mem_fwd_rd(mem_fwd_rd), .mem_fwd_data(mem_fwd_data),
      .wb_fwd_valid(wb_fwd_valid), .wb_fwd_rd(wb_fwd_rd), .wb_fwd_data(wb_fwd_data),
      .id_stall(id_stall), .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_imm(ex_imm),
      .ex_opcode(ex_opcode), .ex_funct7(ex_funct7), .ex_funct3(ex_funct3),
      .ex_rd(ex_rd), .ex_aluIn1(ex_aluIn1), .ex_aluIn2(ex_aluIn2)
   );

   // Reference: the instruction occupying EX plus the operand values it will use.
   typedef struct {
      logic v; logic [31:0] pc, imm, d1, d2; logic [6:0] op, f7; logic [2:0] f3;
      logic [4:0] rd, rs1, rs2;
   } slot_t;
   typedef struct {
      logic v, stall; logic [31:0] pc, imm, a1, a2; logic [6:0] op, f7;
      logic [2:0] f3; logic [4:0] rd;
   } exp_t;

   slot_t m;
   exp_t  sbq[$];
   int    n_cmp = 0;
   int    n_bad = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic reads1(input logic [6:0] op);
      return !(op inside {OP_AUIPC, OP_JAL});
   endfunction
   function automatic logic reads2(input logic [6:0] op);
      return op inside {OP_ALU, OP_BRANCH, OP_STORE};
   endfunction

   // Newest producer of a register wins; x0 always reads the stored value.
   function automatic logic [31:0] m_val(input logic [4:0] rs, input logic [31:0] d);
      if (rs == 0) return d;
      if (mem_fwd_valid && mem_fwd_rd == rs) return mem_fwd_data;
      if (wb_fwd_valid && wb_fwd_rd == rs) return wb_fwd_data;
      return d;
   endfunction

   function automatic logic m_hazard();
      if (!m.v || m.op != OP_LOAD || m.rd == 0 || !id_valid) return 1'b0;
      return (reads1(id_opcode) && id_rs1 == m.rd) || (reads2(id_opcode) && id_rs2 == m.rd);
   endfunction

   function automatic void m_reset();
      m = '{v: 0, pc: 0, imm: 0, d1: 0, d2: 0, op: 0, f7: 0, f3: 0, rd: 0, rs1: 0, rs2: 0};
   endfunction

   task automatic push_expect();
      exp_t e;
      e.v = m.v; e.pc = m.pc; e.imm = m.imm; e.op = m.op; e.f7 = m.f7; e.f3 = m.f3;
      e.rd = m.rd;
      e.a1 = m_val(m.rs1, m.d1);
      e.a2 = m_val(m.rs2, m.d2);
      e.stall = ex_stall || (m_hazard() && !flush);
      sbq.push_back(e);
   endtask

   function automatic void m_edge();
      if (!rst_n) m_reset();
      else if (ex_stall) begin
         m.d1 = m_val(m.rs1, m.d1);
         m.d2 = m_val(m.rs2, m.d2);
      end else if (flush || m_hazard()) m.v = 1'b0;
      else begin
         m.v = id_valid; m.pc = id_pc; m.imm = id_imm; m.op = id_opcode;
         m.f7 = id_funct7; m.f3 = id_funct3; m.rd = id_rd; m.rs1 = id_rs1;
         m.rs2 = id_rs2; m.d1 = id_rs1_data; m.d2 = id_rs2_data;
      end
   endfunction

   // One clock: record expectation for the current inputs, then advance.
   task automatic tick();
      push_expect();
      @(posedge clk);
      m_edge();
      #1;
   endtask

   task automatic set_id(input logic v, input logic [6:0] op, input logic [4:0] rs1,
                         input logic [4:0] rs2, input logic [4:0] rd,
                         input logic [31:0] d1, input logic [31:0] d2);
      id_valid = v; id_opcode = op; id_rs1 = rs1; id_rs2 = rs2; id_rd = rd;
      id_rs1_data = d1; id_rs2_data = d2;
      id_pc = $urandom; id_imm = $urandom; id_funct7 = 7'($urandom); id_funct3 = 3'($urandom);
   endtask

   task automatic clr_ctl();
      ex_stall = 0; flush = 0; mem_fwd_valid = 0; wb_fwd_valid = 0;
      mem_fwd_rd = 0; wb_fwd_rd = 0; mem_fwd_data = $urandom; wb_fwd_data = $urandom;
   endtask

   always @(negedge clk) begin
      if (sbq.size() > 0) begin
         exp_t e;
         e = sbq.pop_front();
         chk("ex_valid", 32'(ex_valid), 32'(e.v));
         chk("id_stall", 32'(id_stall), 32'(e.stall));
         if (e.v) begin
            chk("ex_pc", ex_pc, e.pc);
            chk("ex_imm", ex_imm, e.imm);
            chk("ex_opcode", 32'(ex_opcode), 32'(e.op));
            chk("ex_funct7", 32'(ex_funct7), 32'(e.f7));
            chk("ex_funct3", 32'(ex_funct3), 32'(e.f3));
            chk("ex_rd", 32'(ex_rd), 32'(e.rd));
            chk("ex_aluIn1", ex_aluIn1, e.a1);
            chk("ex_aluIn2", ex_aluIn2, e.a2);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got %0d compared", n_cmp);
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 0;
      clr_ctl();
      set_id(0, OP_ALU, 0, 0, 0, 0, 0);
      m_reset();
      repeat (2) @(posedge clk);
      #1;
      chk("rst_ex_valid", 32'(ex_valid), 0);
      chk("rst_aluIn1", ex_aluIn1, 0);
      chk("rst_id_stall", 32'(id_stall), 0);
      rst_n = 1;

      // 1: basic capture, then asynchronous reset mid-cycle
      set_id(1, OP_ALU, 5, 6, 7, 32'd10, 32'd3);
      tick();
      set_id(0, OP_ALU, 0, 0, 0, 0, 0);
      #1;
      chk("t1_valid", 32'(ex_valid), 1);
      chk("t1_a1", ex_aluIn1, 32'd10);
      chk("t1_a2", ex_aluIn2, 32'd3);
      chk("t1_rd", 32'(ex_rd), 32'd7);
      chk("t1_stall", 32'(id_stall), 0);
      rst_n = 0;
      #1;
      chk("t1_async_rst", 32'(ex_valid), 0);
      m_reset();
      tick();
      rst_n = 1;

      // 2: forwarding priority and x0
      set_id(1, OP_ALU, 5, 6, 9, 32'h1, 32'h2);
      tick();
      set_id(0, OP_ALU, 0, 0, 0, 0, 0);
      mem_fwd_valid = 1; mem_fwd_rd = 5; mem_fwd_data = 32'h11;
      wb_fwd_valid = 1; wb_fwd_rd = 5; wb_fwd_data = 32'h22;
      #1;
      chk("t2_mem_prio", ex_aluIn1, 32'h11);
      mem_fwd_valid = 0;
      #1;
      chk("t2_wb", ex_aluIn1, 32'h22);
      set_id(1, OP_ALU, 0, 0, 9, 32'h77, 32'h66);
      clr_ctl();
      tick();
      set_id(0, OP_ALU, 0, 0, 0, 0, 0);
      mem_fwd_valid = 1; mem_fwd_rd = 0; mem_fwd_data = 32'h11;
      wb_fwd_valid = 1; wb_fwd_rd = 0; wb_fwd_data = 32'h22;
      #1;
      chk("t2_x0", ex_aluIn1, 32'h77);
      clr_ctl();

      // 3: load-use bubble then MEM forwarding
      set_id(1, OP_LOAD, 1, 0, 7, 32'h100, 0);
      tick();
      set_id(1, OP_ALU, 2, 7, 8, 32'h5, 32'h6);
      #1;
      chk("t3_stall", 32'(id_stall), 1);
      tick();
      chk("t3_bubble", 32'(ex_valid), 0);
      chk("t3_nostall", 32'(id_stall), 0);
      tick();
      set_id(0, OP_ALU, 0, 0, 0, 0, 0);
      mem_fwd_valid = 1; mem_fwd_rd = 7; mem_fwd_data = 32'hAB;
      #1;
      chk("t3_valid", 32'(ex_valid), 1);
      chk("t3_fwd", ex_aluIn2, 32'hAB);
      clr_ctl();

      // 4: AUIPC's rs1 field aliasing the load's rd is not a hazard
      set_id(1, OP_LOAD, 1, 0, 7, 32'h100, 0);
      tick();
      set_id(1, OP_AUIPC, 7, 0, 8, 0, 0);
      #1;
      chk("t4_nostall", 32'(id_stall), 0);
      tick();
      chk("t4_enter", 32'(ex_valid), 1);

      // 5: WB retiring during a stall is retained
      set_id(1, OP_ALU, 3, 4, 9, 32'h1, 32'h2);
      tick();
      set_id(0, OP_ALU, 0, 0, 0, 0, 0);
      ex_stall = 1; wb_fwd_valid = 1; wb_fwd_rd = 3; wb_fwd_data = 32'h55;
      #1;
      chk("t5_c1", ex_aluIn1, 32'h55);
      chk("t5_stall1", 32'(id_stall), 1);
      tick();
      wb_fwd_valid = 0;
      #1;
      chk("t5_c2", ex_aluIn1, 32'h55);
      chk("t5_stall2", 32'(id_stall), 1);
      tick();
      ex_stall = 0;
      #1;
      chk("t5_after", ex_aluIn1, 32'h55);
      chk("t5_valid", 32'(ex_valid), 1);

      // 6: flush ignored under stall, honoured otherwise, masks load-use stall
      set_id(1, OP_ALU, 1, 2, 3, 32'h9, 32'h8);
      tick();
      flush = 1; ex_stall = 1;
      tick();
      chk("t6_held", 32'(ex_valid), 1);
      ex_stall = 0;
      tick();
      chk("t6_flushed", 32'(ex_valid), 0);
      flush = 0;
      set_id(1, OP_LOAD, 1, 0, 7, 32'h100, 0);
      tick();
      set_id(1, OP_ALU, 2, 7, 8, 32'h5, 32'h6);
      flush = 1;
      #1;
      chk("t6_flush_lu", 32'(id_stall), 0);
      tick();
      chk("t6_flush_lu_v", 32'(ex_valid), 0);
      clr_ctl();

      // Randomized traffic with a narrow register range to provoke hazards
      for (int i = 0; i < 600; i++) begin
         set_id(1'($urandom_range(0, 3) != 0), OPS[$urandom_range(0, 8)],
                5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                5'($urandom_range(0, 7)), $urandom, $urandom);
         ex_stall = ($urandom_range(0, 4) == 0);
         flush = ($urandom_range(0, 9) == 0);
         mem_fwd_valid = 1'($urandom_range(0, 1));
         mem_fwd_rd = 5'($urandom_range(0, 7));
         mem_fwd_data = $urandom;
         wb_fwd_valid = 1'($urandom_range(0, 1));
         wb_fwd_rd = 5'($urandom_range(0, 7));
         wb_fwd_data = $urandom;
         if (i == 300) begin
            rst_n = 0;
            m_reset();
         end
         if (i == 302) rst_n = 1;
         tick();
      end

      repeat (3) @(posedge clk);
      chk("sb_drain", 32'(sbq.size()), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
